// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
//   Pop-side stage that follows the FIFO. It takes one (DATA_WIDTH+1)-bit word per
//   valid/grant handshake and replays its payload as DATA_WIDTH/OUT_WIDTH narrower
//   beats, least significant chunk first. Bit DATA_WIDTH of the input word is a
//   "last" marker. It is reported on the final beat of that word only.
//
// Ports
//   clk          single clock, all state updates on posedge
//   rst          synchronous reset, active-high
//   in_data_i    word from the FIFO; MSB = last marker, lower bits = payload
//   in_valid_i   FIFO has a word available
//   in_grant_o   serializer takes the word this cycle
//   out_data_o   current beat
//   out_valid_o  out_data_o / out_last_o are valid
//   out_last_o   final beat of a word whose last marker was set
//   out_grant_i  sink accepts the beat this cycle
//   word_count_o (only with SER_WORD_COUNT_EN) saturating count of completed words
//
// Optional feature macro: SER_WORD_COUNT_EN

module fifo_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_grant_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_grant_i
`ifdef SER_WORD_COUNT_EN
  ,
  output logic [15:0]           word_count_o
`endif
);

  localparam int NUM_CHUNKS = DATA_WIDTH / OUT_WIDTH;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  // Parameter sanity: the payload must split evenly into at least two beats.
  if ((DATA_WIDTH % OUT_WIDTH) != 0 || NUM_CHUNKS < 2) begin : g_param_check
    $error("fifo_word_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 chunks");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         chunk_q, chunk_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  last_q, last_d;
  logic                  at_last;
  logic                  accept;
  logic                  beat_done;

  // Handshake and output decode. The grant is a pure function of state, the sink
  // grant and rst (never of in_valid_i), so no combinational loop through the FIFO
  // is possible. Granting on the final beat lets the next word load with no bubble.
  always_comb begin
    at_last     = (chunk_q == LAST_CHUNK);
    out_valid_o = (state_q == SHIFT);
    beat_done   = out_valid_o && out_grant_i;
    in_grant_o  = !rst && ((state_q == IDLE) ||
                           ((state_q == SHIFT) && at_last && out_grant_i));
    accept      = in_valid_i && in_grant_o;
    out_data_o  = word_q[int'(chunk_q) * OUT_WIDTH +: OUT_WIDTH];
    out_last_o  = (state_q == SHIFT) && last_q && at_last;
  end

  // Next-state logic. A stalled beat (valid without grant) leaves everything
  // untouched, which is what keeps data, last and chunk stable under backpressure.
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    word_d  = word_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = in_data_i[DATA_WIDTH-1:0];
          last_d  = in_data_i[DATA_WIDTH];
          chunk_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_done) begin
          if (!at_last) begin
            chunk_d = chunk_q + CW'(1);
          end else if (accept) begin
            word_d  = in_data_i[DATA_WIDTH-1:0];
            last_d  = in_data_i[DATA_WIDTH];
            chunk_d = '0;
          end else begin
            chunk_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chunk_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

`ifdef SER_WORD_COUNT_EN
  // A word is complete when its final beat is taken; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_o <= '0;
    end else if (beat_done && at_last && (word_count_o != 16'hFFFF)) begin
      word_count_o <= word_count_o + 16'd1;
    end
  end
`endif

endmodule
